// File: rtl/seq_sub_divider.sv
// -----------------------------------------------------------------------------
// seq_sub_divider
// Multi-cycle unsigned divider controller using repeated subtraction.
// Computes Quotient = Dividend / Divisor and Remainder = Dividend % Divisor
// with a Start/Busy/Done handshake. One subtraction per RUN cycle, so the
// latency grows with the quotient (q+2 edges from accept to end of Done).
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor ends the run on the first RUN cycle with
//               Quotient=all-ones, Remainder=Dividend, DivByZero=1.
//   undefined : DivByZero is tied 0; a zero divisor runs until the quotient
//               saturates at all-ones, which gives the same Q/R results.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   Start      in   request, sampled only in IDLE
//   Dividend   in   [N-1:0] unsigned dividend, captured on the accepting edge
//   Divisor    in   [N-1:0] unsigned divisor, captured on the accepting edge
//   Busy       out  high while the divider is in RUN
//   Done       out  one-cycle pulse when the results are valid
//   Quotient   out  [N-1:0] quotient, held until the next accepted Start
//   Remainder  out  [N-1:0] remainder, held until the next accepted Start
//   DivByZero  out  divide-by-zero flag, valid with Done
// -----------------------------------------------------------------------------
module seq_sub_divider #(
   parameter int N = 5
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [N-1:0] Dividend,
   input  logic [N-1:0] Divisor,
   output logic         Busy,
   output logic         Done,
   output logic [N-1:0] Quotient,
   output logic [N-1:0] Remainder,
   output logic         DivByZero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [N-1:0] ZERO_C = {N{1'b0}};
   localparam logic [N-1:0] ONES_C = {N{1'b1}};
   localparam logic [N-1:0] ONE_C  = {{(N-1){1'b0}}, 1'b1};

   state_t       state_r;
   state_t       next_state_s;
   logic [N-1:0] rem_r;
   logic [N-1:0] rem_nxt_s;
   logic [N-1:0] div_r;
   logic [N-1:0] div_nxt_s;
   logic [N-1:0] quo_r;
   logic [N-1:0] quo_nxt_s;
   logic         busy_r;
   logic         done_r;
   logic [N:0]   diff_s;
   logic         borrow_s;
   logic         q_sat_s;

`ifdef DIV_ZERO_DETECT_EN
   logic         dbz_r;
   logic         dbz_nxt_s;
   logic         div_zero_s;
`endif

   // The extra top bit turns the subtractor borrow into the R<D compare.
   assign diff_s   = {1'b0, rem_r} - {1'b0, div_r};
   assign borrow_s = diff_s[N];
   assign q_sat_s  = (quo_r == ONES_C);

`ifdef DIV_ZERO_DETECT_EN
   assign div_zero_s = (div_r == ZERO_C);
`endif

   // Next-state and datapath update decode.
   always_comb begin
      next_state_s = state_r;
      rem_nxt_s    = rem_r;
      div_nxt_s    = div_r;
      quo_nxt_s    = quo_r;
`ifdef DIV_ZERO_DETECT_EN
      dbz_nxt_s    = dbz_r;
`endif
      case (state_r)
         IDLE: begin
            if (Start) begin
               rem_nxt_s    = Dividend;
               div_nxt_s    = Divisor;
               quo_nxt_s    = ZERO_C;
`ifdef DIV_ZERO_DETECT_EN
               dbz_nxt_s    = 1'b0;
`endif
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            // Priority: zero divisor (optional), R<D, saturation, subtract.
`ifdef DIV_ZERO_DETECT_EN
            if (div_zero_s) begin
               quo_nxt_s    = ONES_C;
               dbz_nxt_s    = 1'b1;
               next_state_s = DONE;
            end else
`endif
            if (borrow_s) begin
               next_state_s = DONE;
            end else if (q_sat_s) begin
               // Only reachable with a zero divisor; bounds the run length.
               next_state_s = DONE;
            end else begin
               rem_nxt_s    = diff_s[N-1:0];
               quo_nxt_s    = quo_r + ONE_C;
               next_state_s = RUN;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Remainder, divisor and quotient registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rem_r <= ZERO_C;
         div_r <= ZERO_C;
         quo_r <= ZERO_C;
      end else begin
         rem_r <= rem_nxt_s;
         div_r <= div_nxt_s;
         quo_r <= quo_nxt_s;
      end
   end

   // Handshake flags registered from the next state so they align with it.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (next_state_s == RUN);
         done_r <= (next_state_s == DONE);
      end
   end

`ifdef DIV_ZERO_DETECT_EN
   // Divide-by-zero flag, cleared on accept and set by the zero-divisor exit.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         dbz_r <= 1'b0;
      end else begin
         dbz_r <= dbz_nxt_s;
      end
   end

   assign DivByZero = dbz_r;
`else
   assign DivByZero = 1'b0;
`endif

   assign Busy      = busy_r;
   assign Done      = done_r;
   assign Quotient  = quo_r;
   assign Remainder = rem_r;

endmodule

// File: tb/tb_seq_sub_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_sub_divider
// Directed-vector bench for seq_sub_divider (N=5). Stimulus pushes the
// hand-computed result, the cycle on which Done must be seen and the number
// of Busy cycles into a scoreboard; a monitor pops and compares on Done.
// -----------------------------------------------------------------------------
module tb_seq_sub_divider;

   localparam int N = 5;

   logic         Clk;
   logic         Reset;
   logic         Start;
   logic [N-1:0] Dividend;
   logic [N-1:0] Divisor;
   logic         Busy;
   logic         Done;
   logic [N-1:0] Quotient;
   logic [N-1:0] Remainder;
   logic         DivByZero;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
      int           done_cyc;
      int           busy;
   } exp_t;

   exp_t sb[$];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;

   seq_sub_divider #(.N(N)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Busy      (Busy),
      .Done      (Done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivByZero (DivByZero)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare on every Done pulse, count Busy cycles in between.
   always @(negedge Clk) begin
      if (!Reset) begin
         busy_cnt = 0;
      end else if (Done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: Done seen with no pending request (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient",  32'(Quotient),  32'(e.q));
            check("remainder", 32'(Remainder), 32'(e.r));
            check("divbyzero", 32'(DivByZero), 32'(e.dbz));
            check("done_cycle", 32'(cyc),      32'(e.done_cyc));
            check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
         end
         busy_cnt = 0;
      end else if (Busy) begin
         busy_cnt++;
      end
   end

   // Push an expectation for a request accepted on the next edge.
   // 'e' is the edge index (after accept) on which Done rises.
   task automatic push_exp(input logic [N-1:0] q, input logic [N-1:0] r,
                           input logic dbz, input int e);
      exp_t x;
      x.q        = q;
      x.r        = r;
      x.dbz      = dbz;
      x.done_cyc = cyc + 1 + e;
      x.busy     = e;
      sb.push_back(x);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge Clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: %0d result(s) never completed", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic dbz, input int e);
      @(negedge Clk);
      Dividend = dvd;
      Divisor  = dvs;
      Start    = 1'b1;
      push_exp(q, r, dbz, e);
      @(negedge Clk);
      Start    = 1'b0;
      Dividend = 5'd0;
      Divisor  = 5'd0;
      wait_idle();
   endtask

   initial begin
      Reset    = 1'b0;
      Start    = 1'b0;
      Dividend = 5'd0;
      Divisor  = 5'd0;
      repeat (3) @(negedge Clk);
      check("rst_busy",      32'(Busy),      32'd0);
      check("rst_done",      32'(Done),      32'd0);
      check("rst_quotient",  32'(Quotient),  32'd0);
      check("rst_remainder", 32'(Remainder), 32'd0);
      check("rst_divbyzero", 32'(DivByZero), 32'd0);
      Reset = 1'b1;

      // Basic: 13/4 = 3 r 1, Done after edge 4.
      run_op(5'd13, 5'd4, 5'd3, 5'd1, 1'b0, 4);
      // Minimum latency: 3/7 = 0 r 3.
      run_op(5'd3, 5'd7, 5'd0, 5'd3, 1'b0, 1);
      // Maximum latency: 31/1 = 31 r 0, Done after edge 32.
      run_op(5'd31, 5'd1, 5'd31, 5'd0, 1'b0, 32);
      // Divide by zero.
`ifdef DIV_ZERO_DETECT_EN
      run_op(5'd9, 5'd0, 5'd31, 5'd9, 1'b1, 1);
`else
      run_op(5'd9, 5'd0, 5'd31, 5'd9, 1'b0, 32);
`endif

      // Start during RUN is ignored: 20/3 = 6 r 2, single Done.
      @(negedge Clk);
      Dividend = 5'd20;
      Divisor  = 5'd3;
      Start    = 1'b1;
      push_exp(5'd6, 5'd2, 1'b0, 7);
      @(negedge Clk);
      Start    = 1'b0;
      @(negedge Clk);
      Dividend = 5'd30;
      Divisor  = 5'd1;
      Start    = 1'b1;
      repeat (2) @(negedge Clk);
      Start    = 1'b0;
      wait_idle();
      repeat (3) @(negedge Clk);
      check("held_quotient",  32'(Quotient),  32'd6);
      check("held_remainder", 32'(Remainder), 32'd2);

      // Back-to-back: Start held; 13/4 then 7/2 (= 3 r 1).
      @(negedge Clk);
      Dividend = 5'd13;
      Divisor  = 5'd4;
      Start    = 1'b1;
      push_exp(5'd3, 5'd1, 1'b0, 4);
      repeat (6) @(negedge Clk);
      Dividend = 5'd7;
      Divisor  = 5'd2;
      push_exp(5'd3, 5'd1, 1'b0, 4);
      @(negedge Clk);
      Start    = 1'b0;
      wait_idle();

      // Reset in the middle of a 20/3 run: outputs clear, no Done.
      @(negedge Clk);
      Dividend = 5'd20;
      Divisor  = 5'd3;
      Start    = 1'b1;
      @(negedge Clk);
      Start    = 1'b0;
      repeat (2) @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      check("abort_busy",      32'(Busy),      32'd0);
      check("abort_done",      32'(Done),      32'd0);
      check("abort_quotient",  32'(Quotient),  32'd0);
      check("abort_remainder", 32'(Remainder), 32'd0);
      check("abort_divbyzero", 32'(DivByZero), 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      // After release: 8/2 = 4 r 0.
      run_op(5'd8, 5'd2, 5'd4, 5'd0, 1'b0, 5);

      // Any stray Done here is flagged by the monitor.
      repeat (10) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
